// File: rtl/sr_flag_ctrl.sv
// Controller for a bank of set/reset latches: two valid/ready requesters share the
// bank through a round-robin arbiter; an FSM shapes S/R pulses and shadows the latch state.
module sr_flag_ctrl #(
  parameter int NUM_FLAGS      = 8,
  parameter int IDX_W          = 3,
  parameter int HOLD_CYCLES    = 2,
  parameter int RESET_DOMINANT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [1:0]           req0_op,
  input  logic [IDX_W-1:0]     req0_idx,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [1:0]           req1_op,
  input  logic [IDX_W-1:0]     req1_idx,
  output logic                 req1_ready,
  output logic [NUM_FLAGS-1:0] s_out,
  output logic [NUM_FLAGS-1:0] r_out,
  output logic [NUM_FLAGS-1:0] flags,
  output logic                 busy,
  output logic [7:0]           conflict_cnt
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_DRIVE, ST_RECOVER} state_t;

  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_TGL = 2'b11;

  localparam int CNT_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES);

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic                 ptr;
  logic [IDX_W-1:0]     drv_idx;
  logic                 drv_set;
  logic [NUM_FLAGS-1:0] s_d, r_d;

  logic                 idle, same_idx, pair_conflict, merge;
  logic                 grant0, grant1, accept;
  logic [1:0]           sel_op;
  logic [IDX_W-1:0]     sel_idx;
  logic                 in_range, flag_now;
  logic                 do_drive, set_dir;
  logic                 drive_done;
  logic [NUM_FLAGS-1:0] drv_mask;

  function automatic logic [NUM_FLAGS-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = '0;
    for (int i = 0; i < NUM_FLAGS; i++)
      if (idx == IDX_W'(i)) onehot[i] = 1'b1;
  endfunction

  // Arbitration: a merge accepts both requesters at once and leaves the pointer alone.
  assign idle          = (state == ST_IDLE);
  assign same_idx      = (req0_idx == req1_idx);
  assign pair_conflict = ((req0_op == OP_SET) && (req1_op == OP_CLR)) ||
                         ((req0_op == OP_CLR) && (req1_op == OP_SET));
  assign merge         = req0_valid && req1_valid && same_idx &&
                         ((req0_op == req1_op) || pair_conflict);
  assign grant0        = idle && req0_valid && (!req1_valid || merge || !ptr);
  assign grant1        = idle && req1_valid && (!req0_valid || merge ||  ptr);
  assign accept        = grant0 || grant1;
  assign req0_ready    = grant0;
  assign req1_ready    = grant1;

  assign sel_op   = grant0 ? req0_op  : req1_op;
  assign sel_idx  = grant0 ? req0_idx : req1_idx;
  assign in_range = (int'(sel_idx) < NUM_FLAGS);
  assign flag_now = |(flags & onehot(sel_idx));

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    do_drive = 1'b0;
    set_dir  = 1'b0;
    if (accept && in_range) begin
      if (merge && pair_conflict) begin
        do_drive = 1'b1;
        set_dir  = (RESET_DOMINANT == 0);
      end else begin
        case (sel_op)
          OP_SET:  begin do_drive = 1'b1; set_dir = 1'b1;      end
          OP_CLR:  begin do_drive = 1'b1; set_dir = 1'b0;      end
          OP_TGL:  begin do_drive = 1'b1; set_dir = !flag_now; end
          default: ;
        endcase
      end
    end
  end

  assign drive_done = (state == ST_DRIVE) && (cnt == HOLD_LAST);
  assign drv_mask   = onehot(drv_idx);

  // Outputs are registered from the next state so reset can force them low at once.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    s_d     = '0;
    r_d     = '0;
    case (state)
      ST_INIT: begin
        if (cnt == HOLD_LAST) begin
          state_d = ST_RECOVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
          r_d   = '1;
        end
      end
      ST_IDLE: begin
        if (do_drive) begin
          state_d = ST_DRIVE;
          cnt_d   = CNT_W'(1);
          if (set_dir) s_d = onehot(sel_idx);
          else         r_d = onehot(sel_idx);
        end
      end
      ST_DRIVE: begin
        if (cnt == HOLD_LAST) begin
          state_d = ST_RECOVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
          if (drv_set) s_d = drv_mask;
          else         r_d = drv_mask;
        end
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_INIT;
      cnt          <= '0;
      ptr          <= 1'b0;
      drv_idx      <= '0;
      drv_set      <= 1'b0;
      s_out        <= '0;
      r_out        <= '0;
      flags        <= '0;
      conflict_cnt <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      s_out <= s_d;
      r_out <= r_d;
      if (accept && !merge) ptr <= grant0;
      if (idle && do_drive) begin
        drv_idx <= sel_idx;
        drv_set <= set_dir;
      end
      if (drive_done)
        flags <= drv_set ? (flags | drv_mask) : (flags & ~drv_mask);
      if (accept && merge && pair_conflict && (conflict_cnt != 8'hFF))
        conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sr_flag_ctrl.sv
// Directed bench for sr_flag_ctrl with IDX_W=4, so indices past the bank can be issued.
module tb_sr_flag_ctrl;

  localparam int NF = 8;
  localparam int IW = 4;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic [1:0]    req0_op, req1_op;
  logic [IW-1:0] req0_idx, req1_idx;
  logic          req0_ready, req1_ready;
  logic [NF-1:0] s_out, r_out, flags;
  logic          busy;
  logic [7:0]    conflict_cnt;

  int checks   = 0;
  int failures = 0;

  sr_flag_ctrl #(
    .NUM_FLAGS(NF), .IDX_W(IW), .HOLD_CYCLES(2), .RESET_DOMINANT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_idx(req0_idx), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_idx(req1_idx), .req1_ready(req1_ready),
    .s_out(s_out), .r_out(r_out), .flags(flags), .busy(busy), .conflict_cnt(conflict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [NF-1:0] s_exp,
                            input logic [NF-1:0] r_exp);
    check({tag, "_s"}, 32'(s_out), 32'(s_exp));
    check({tag, "_r"}, 32'(r_out), 32'(r_exp));
    check({tag, "_overlap"}, 32'(s_out & r_out), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b01; req0_idx = 4'd3;
    req1_valid = 1'b0; req1_op = 2'b00; req1_idx = 4'd0;
    #2;
    check_outs("rst", 8'h00, 8'h00);
    check("rst_flags", 32'(flags), 32'h00);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_cnt", 32'(conflict_cnt), 32'd0);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // INIT: r_out all ones for two cycles, one quiet cycle, then IDLE.
    tick();
    check_outs("init1", 8'h00, 8'hFF);
    check("init1_ready0", 32'(req0_ready), 32'd0);
    tick();
    check_outs("init2", 8'h00, 8'hFF);
    tick();
    check_outs("init3", 8'h00, 8'h00);
    check("init3_busy", 32'(busy), 32'd1);
    check("init3_ready0", 32'(req0_ready), 32'd0);
    tick();
    // Cycle T: the set idx3 held through INIT is accepted.
    check("idle_busy", 32'(busy), 32'd0);
    check("t_ready0", 32'(req0_ready), 32'd1);
    check("t_flags", 32'(flags), 32'h00);
    tick();
    req0_valid = 1'b0;
    check_outs("t1", 8'h08, 8'h00);
    tick();
    check_outs("t2", 8'h08, 8'h00);
    check("t2_flags", 32'(flags), 32'h00);
    tick();
    req0_valid = 1'b1; req0_op = 2'b00; req0_idx = 4'd0;
    #1;
    check_outs("t3", 8'h00, 8'h00);
    check("t3_flags", 32'(flags), 32'h08);
    check("t3_ready0", 32'(req0_ready), 32'd0);
    tick();
    check("t4_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    #1;
    check("nop_busy", 32'(busy), 32'd0);
    check_outs("nop", 8'h00, 8'h00);

    // Both requesters valid; pointer sits at requester 1 after two req0 grants.
    req0_valid = 1'b1; req0_op = 2'b01; req0_idx = 4'd1;
    req1_valid = 1'b1; req1_op = 2'b01; req1_idx = 4'd2;
    #1;
    check("a0_ready0", 32'(req0_ready), 32'd0);
    check("a0_ready1", 32'(req1_ready), 32'd1);
    tick();
    check_outs("a1", 8'h04, 8'h00);
    tick();
    check_outs("a2", 8'h04, 8'h00);
    tick();
    check("a3_flags", 32'(flags), 32'h0C);
    check("a3_ready0", 32'(req0_ready), 32'd0);
    check("a3_ready1", 32'(req1_ready), 32'd0);
    tick();
    check("a4_ready0", 32'(req0_ready), 32'd1);
    check("a4_ready1", 32'(req1_ready), 32'd0);
    tick();
    check_outs("a5", 8'h02, 8'h00);
    tick();
    check_outs("a6", 8'h02, 8'h00);
    tick();
    check("a7_flags", 32'(flags), 32'h0E);
    tick();
    check("a8_ready0", 32'(req0_ready), 32'd0);
    check("a8_ready1", 32'(req1_ready), 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("a9_busy", 32'(busy), 32'd0);
    check("a9_flags", 32'(flags), 32'h0E);

    // Set/clear conflict on idx5 merges into one clear pulse.
    req0_valid = 1'b1; req0_op = 2'b01; req0_idx = 4'd5;
    req1_valid = 1'b1; req1_op = 2'b10; req1_idx = 4'd5;
    #1;
    check("b0_ready0", 32'(req0_ready), 32'd1);
    check("b0_ready1", 32'(req1_ready), 32'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check_outs("b1", 8'h00, 8'h20);
    check("b1_cnt", 32'(conflict_cnt), 32'd1);
    tick();
    check_outs("b2", 8'h00, 8'h20);
    tick();
    check_outs("b3", 8'h00, 8'h00);
    check("b3_flags", 32'(flags), 32'h0E);
    tick();
    for (int i = 0; i < 299; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick(); tick(); tick();
    end
    check("sat_cnt", 32'(conflict_cnt), 32'd255);
    check("sat_busy", 32'(busy), 32'd0);
    check("sat_flags", 32'(flags), 32'h0E);

    // Toggle idx0 twice: a set pulse, then a clear pulse.
    req0_valid = 1'b1; req0_op = 2'b11; req0_idx = 4'd0;
    #1;
    check("tg1_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    check_outs("tg1", 8'h01, 8'h00);
    tick(); tick();
    check("tg1_flags", 32'(flags), 32'h0F);
    tick();
    req0_valid = 1'b1;
    #1;
    check("tg2_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    check_outs("tg2", 8'h00, 8'h01);
    tick(); tick();
    check("tg2_flags", 32'(flags), 32'h0E);
    tick();

    // Out-of-range index and nop: accepted, no drive, stays idle.
    req1_valid = 1'b1; req1_op = 2'b01; req1_idx = 4'd9;
    #1;
    check("oor_ready1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    check("oor_busy", 32'(busy), 32'd0);
    check_outs("oor", 8'h00, 8'h00);
    req0_valid = 1'b1; req0_op = 2'b00; req0_idx = 4'd2;
    #1;
    check("nop2_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    check("nop2_busy", 32'(busy), 32'd0);
    check_outs("nop2", 8'h00, 8'h00);
    check("nop2_flags", 32'(flags), 32'h0E);

    // Reset during the second DRIVE cycle of a set idx6.
    req0_valid = 1'b1; req0_op = 2'b01; req0_idx = 4'd6;
    tick();
    req0_valid = 1'b0;
    check_outs("d1", 8'h40, 8'h00);
    tick();
    check_outs("d2", 8'h40, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("mid_rst", 8'h00, 8'h00);
    check("mid_rst_flags", 32'(flags), 32'h00);
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_cnt", 32'(conflict_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_outs("reinit1", 8'h00, 8'hFF);
    tick();
    check_outs("reinit2", 8'h00, 8'hFF);
    tick();
    check_outs("reinit3", 8'h00, 8'h00);
    check("reinit3_busy", 32'(busy), 32'd1);
    tick();
    check("reinit4_busy", 32'(busy), 32'd0);
    check("reinit4_flags", 32'(flags), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_flag_ctrl.md
Name: sr_flag_ctrl

Overview:
- Clocked controller that owns a bank of NUM_FLAGS set/reset latches and drives each latch's S and R inputs.
- Two requesters issue set, clear, toggle or no-op commands over valid/ready handshakes.
- A round-robin arbiter shares the bank between them.
- An FSM enforces a minimum S/R pulse width and a recovery gap, never drives S and R together, and keeps a shadow copy of the latch state.

Parameters:
- NUM_FLAGS, 8, number of latches in the bank.
- IDX_W, 3, flag index width; must satisfy 2**IDX_W >= NUM_FLAGS.
- HOLD_CYCLES, 2, cycles S or R is held high per command; minimum 1.
- RESET_DOMINANT, 1, same-cycle same-index set/clear conflict resolves to clear (1) or set (0).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 command valid.
- req0_op  in  2  00 nop, 01 set, 10 clear, 11 toggle.
- req0_idx  in  IDX_W  target flag index.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req1_valid, req1_op, req1_idx, req1_ready  as requester 0.
- s_out  out  NUM_FLAGS  per-latch set drive.
- r_out  out  NUM_FLAGS  per-latch reset drive.
- flags  out  NUM_FLAGS  shadow latch state.
- busy  out  1  high in every state except IDLE.
- conflict_cnt  out  8  saturating count of merged set/clear conflicts.

Behaviour:
- Reset (rst_n low, asynchronous):
  - s_out, r_out, flags, conflict_cnt, ready = 0.
  - busy = 1; state = INIT; round-robin pointer = requester 0.
- Reset asserted mid-operation clears s_out/r_out immediately and abandons the command.
- States and transitions:
  - INIT: r_out all ones for HOLD_CYCLES cycles, then RECOVER. This forces every latch to 0 to match flags.
  - IDLE: arbitrate. On an accepted command that needs a drive, go to DRIVE next cycle.
  - DRIVE: exactly one of s_out[idx] or r_out[idx] high for HOLD_CYCLES cycles; all other bits 0. Then RECOVER.
  - RECOVER: one cycle with all s_out/r_out low (latch hold), then IDLE.
- Invariant: s_out[i] & r_out[i] is never 1, in any state.
- Handshake:
  - readyN is asserted only in IDLE, only to the granted requester(s).
  - readyN may depend combinationally on the valid inputs.
  - A command transfers when validN & readyN.
  - Requesters hold op/idx stable until accepted.
- Arbitration in IDLE:
  - One valid: it is granted. Pointer moves to the other requester.
  - Both valid, different idx, or same idx with non-conflicting distinct ops: the requester at the pointer wins; the pointer moves to the loser, which waits.
  - Both valid, same idx, same op: both accepted in the same cycle; one drive; pointer unchanged.
  - Both valid, same idx, one set and one clear: both accepted; drive is clear if RESET_DOMINANT=1, else set; conflict_cnt += 1, saturating at 255; pointer unchanged.
- Toggle resolves in IDLE from the shadow flag: set if flags[idx]=0, else clear. Toggle versus set/clear on the same idx is treated as "different": arbitrated, not merged.
- Nop: accepted, no drive, state stays IDLE; pointer rules apply.
- idx >= NUM_FLAGS: accepted, treated as nop.
- Latency, for acceptance at cycle T:
  - Drive high during T+1 .. T+HOLD_CYCLES.
  - flags[idx] updates at the edge ending DRIVE, so it is visible at T+HOLD_CYCLES+1.
  - RECOVER at T+HOLD_CYCLES+1; IDLE and next acceptance at T+HOLD_CYCLES+2.
- Setting an already-set flag, or clearing an already-clear flag, still performs the full drive sequence.

Test Plan:
- Reset release, HOLD_CYCLES=2 → r_out=8'hFF for 2 cycles, 1 cycle of zeros, busy falls on cycle 4; flags=0, no ready before IDLE.
- req0 set idx 3 accepted at T → s_out=8'h08 at T+1,T+2; s_out=0 at T+3; flags=8'h08 at T+3; req0_ready again possible at T+4.
- Both valid continuously: req0 set idx1, req1 set idx2 → grants alternate req0, req1; s_out/r_out never overlap; flags=8'h06 after 8 cycles.
- Same cycle, req0 set idx5, req1 clear idx5, RESET_DOMINANT=1 → both ready in one cycle; r_out=8'h20 for 2 cycles; flags[5]=0; conflict_cnt=1. Repeat 300 times → conflict_cnt=255.
- Toggle idx0 twice from 0 → first an s_out pulse (flags=1), then an r_out pulse (flags=0). Nop and idx 9 (IDX_W=4) → ready, no drive, busy stays 0.
- rst_n low during the second DRIVE cycle → s_out/r_out drop to 0 asynchronously, flags=0, INIT sequence restarts on release.
